param_regmap: RTL and testbench

PARAM_REGMAP -- requirements
Module: param_regmap

---
 rtl/param_regmap_pkg.sv | 22 ++
 rtl/param_regmap_w1c.sv | 41 ++++
 rtl/param_regmap.sv | 111 +++++++++++
 tb/tb_param_regmap.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/param_regmap_pkg.sv
// param_regmap_pkg: shared types and defaults for the parameterised register map.
//   acc_e    : access type of a register (RW control or W1C status)
//   DEF_*    : default DW/AW/NREG/NCTRL values used by param_regmap
//   reg_acc  : maps a register index to its access type
package param_regmap_pkg;

  typedef enum logic {
    ACC_RW  = 1'b0,
    ACC_W1C = 1'b1
  } acc_e;

  localparam int DEF_DW    = 8;
  localparam int DEF_AW    = 3;
  localparam int DEF_NREG  = 8;
  localparam int DEF_NCTRL = 4;

  // Registers below nctrl are control (RW); the rest are status (W1C).
  function automatic acc_e reg_acc(input int idx, input int nctrl);
    return (idx < nctrl) ? ACC_RW : ACC_W1C;
  endfunction

endpackage

// File: rtl/param_regmap_w1c.sv
// regmap_w1c_reg: one write-1-to-clear status register with hardware set strobes.
//   CLK, RST   : clock, synchronous active-high reset
//   set_i      : per-bit set strobes from hardware
//   clr_mask_i : software write data; 1 bits clear when we_i is high
//   we_i       : software write enable for this register
//   q_o        : current register value
module regmap_w1c_reg #(
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [DW-1:0] set_i,
  input  logic [DW-1:0] clr_mask_i,
  input  logic          we_i,
  output logic [DW-1:0] q_o
);

  logic [DW-1:0] q_q;
  logic [DW-1:0] q_d;

  // Clear is applied first and set ORed in last, so a hardware set beats a
  // same-cycle software clear of the same bit.
  always_comb begin
    q_d = q_q;
    if (we_i) begin
      q_d = q_d & ~clr_mask_i;
    end
    q_d = q_d | set_i;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/param_regmap.sv
// param_regmap: parameterised register map with RW control and W1C status registers.
//   CLK, RST             : clock, synchronous active-high reset
//   WRITE, READ, ADDR    : one access of each kind per asserted cycle, no back-pressure
//   WRITE_DATA           : write data (load for control, clear mask for status)
//   READ_DATA/READ_VALID : registered read response, one cycle after READ
//   ERR                  : one-cycle pulse, one cycle after an access with ADDR >= NREG
//   CTRL_OUT             : control registers concatenated, register 0 in the LSBs
//   STAT_SET             : per-bit set strobes for status registers, register NCTRL in the LSBs
//   IRQ                  : registered OR of all status bits
//
// Response protocol: READ_VALID is a single-cycle pulse with no ready; READ_DATA
// is meaningful only while READ_VALID=1 and otherwise holds its last value.
// Every READ produces exactly one pulse one cycle later, unless reset intervenes.
module param_regmap
  import param_regmap_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int AW    = DEF_AW,
  parameter int NREG  = DEF_NREG,
  parameter int NCTRL = DEF_NCTRL
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     WRITE,
  input  logic                     READ,
  input  logic [AW-1:0]            ADDR,
  input  logic [DW-1:0]            WRITE_DATA,
  output logic [DW-1:0]            READ_DATA,
  output logic                     READ_VALID,
  output logic                     ERR,
  output logic [NCTRL*DW-1:0]      CTRL_OUT,
  input  logic [(NREG-NCTRL)*DW-1:0] STAT_SET,
  output logic                     IRQ
);

  localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

  logic [NREG-1:0][DW-1:0] reg_val;
  logic [NREG-1:0]         wr_sel;
  logic                    addr_ok;
  logic [DW-1:0]           rd_mux;
  logic                    irq_d;

  logic [DW-1:0] rdata_q;
  logic          rvalid_q;
  logic          err_q;
  logic          irq_q;

  assign addr_ok = ({1'b0, ADDR} < NREG_W);

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    assign wr_sel[i] = WRITE && (ADDR == AW'(i));

    if (reg_acc(i, NCTRL) == ACC_RW) begin : g_ctrl
      logic [DW-1:0] ctrl_q;
      always_ff @(posedge CLK) begin
        if (RST) begin
          ctrl_q <= '0;
        end else if (wr_sel[i]) begin
          ctrl_q <= WRITE_DATA;
        end
      end
      assign reg_val[i]            = ctrl_q;
      assign CTRL_OUT[i*DW +: DW]  = ctrl_q;
    end else begin : g_stat
      regmap_w1c_reg #(.DW(DW)) u_w1c (
        .CLK        (CLK),
        .RST        (RST),
        .set_i      (STAT_SET[(i-NCTRL)*DW +: DW]),
        .clr_mask_i (WRITE_DATA),
        .we_i       (wr_sel[i]),
        .q_o        (reg_val[i])
      );
    end
  end

  // Out-of-range addresses match no entry and fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NREG; i++) begin
      if (ADDR == AW'(i)) begin
        rd_mux = reg_val[i];
      end
    end
  end

  assign irq_d = |reg_val[NREG-1:NCTRL];

  always_ff @(posedge CLK) begin
    if (RST) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      rvalid_q <= READ;
      err_q    <= (READ || WRITE) && !addr_ok;
      irq_q    <= irq_d;
      if (READ) begin
        rdata_q <= rd_mux;
      end
    end
  end

  assign READ_DATA  = rdata_q;
  // A response already in flight when reset arrives is dropped, not presented.
  assign READ_VALID = rvalid_q && !RST;
  assign ERR        = err_q;
  assign IRQ        = irq_q;

endmodule

// File: tb/tb_param_regmap.sv
module tb_param_regmap;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int NREG  = 6;
  localparam int NCTRL = 4;
  localparam int NSTAT = NREG - NCTRL;

  // clock / reset
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic                  WRITE = 1'b0;
  logic                  READ  = 1'b0;
  logic [AW-1:0]         ADDR  = '0;
  logic [DW-1:0]         WRITE_DATA = '0;
  logic [DW-1:0]         READ_DATA;
  logic                  READ_VALID;
  logic                  ERR;
  logic [NCTRL*DW-1:0]   CTRL_OUT;
  logic [NSTAT*DW-1:0]   STAT_SET = '0;
  logic                  IRQ;

  param_regmap #(.DW(DW), .AW(AW), .NREG(NREG), .NCTRL(NCTRL)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .WRITE      (WRITE),
    .READ       (READ),
    .ADDR       (ADDR),
    .WRITE_DATA (WRITE_DATA),
    .READ_DATA  (READ_DATA),
    .READ_VALID (READ_VALID),
    .ERR        (ERR),
    .CTRL_OUT   (CTRL_OUT),
    .STAT_SET   (STAT_SET),
    .IRQ        (IRQ)
  );

  // reference model: register contents plus expected registered outputs
  logic [DW-1:0] m_reg [NREG];
  logic [DW-1:0] m_rdata;
  logic          m_valid, m_err, m_irq;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] m_ctrl();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < NCTRL; i++) v[i*DW +: DW] = m_reg[i];
    return v;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < NREG; i++) m_reg[i] = '0;
    m_rdata = '0;
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_irq   = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, 32'(READ_VALID), 32'(m_valid));
    chk({tag, ".rdata"}, 32'(READ_DATA),  32'(m_rdata));
    chk({tag, ".err"},   32'(ERR),        32'(m_err));
    chk({tag, ".irq"},   32'(IRQ),        32'(m_irq));
    chk({tag, ".ctrl"},  32'(CTRL_OUT),   m_ctrl());
  endtask

  // driver: one bus cycle, model update at the edge, check 1 time unit later
  task automatic cyc(input string tag, input logic w, input logic r, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic [NSTAT*DW-1:0] s);
    logic any_stat;
    int   ai;
    WRITE = w; READ = r; ADDR = a; WRITE_DATA = d; STAT_SET = s;
    @(posedge CLK);
    ai = int'(a);
    any_stat = 1'b0;
    for (int i = NCTRL; i < NREG; i++) any_stat |= (m_reg[i] != '0);
    m_irq   = any_stat;
    m_valid = r;
    m_err   = (w || r) && (ai >= NREG);
    if (r) m_rdata = (ai < NREG) ? m_reg[ai] : '0;
    if (w && ai < NREG) begin
      if (ai < NCTRL) m_reg[ai] = d;
      else            m_reg[ai] = m_reg[ai] & ~d;
    end
    for (int i = NCTRL; i < NREG; i++) m_reg[i] |= s[(i-NCTRL)*DW +: DW];
    #1;
    WRITE = 1'b0; READ = 1'b0; STAT_SET = '0;
    check_outputs(tag);
  endtask

  initial begin
    m_clear();
    // reset state
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check_outputs("reset");
    RST = 1'b0;

    // write/read a control register
    cyc("wr2", 1, 0, 3'd2, 8'hA5, '0);
    cyc("rd2", 0, 1, 3'd2, 8'h00, '0);
    chk("rd2_const", 32'(READ_DATA), 32'hA5);
    chk("rd2_valid", 32'(READ_VALID), 32'h1);
    chk("rd2_err", 32'(ERR), 32'h0);

    // status set, IRQ lag, W1C clear
    cyc("set4", 0, 0, 3'd0, 8'h00, 16'h0008);
    chk("set4_irq_lag", 32'(IRQ), 32'h0);
    cyc("rd4", 0, 1, 3'd4, 8'h00, '0);
    chk("rd4_const", 32'(READ_DATA), 32'h08);
    chk("rd4_irq", 32'(IRQ), 32'h1);
    cyc("clr4", 1, 0, 3'd4, 8'h08, '0);
    cyc("clr4_idle", 0, 0, 3'd0, 8'h00, '0);
    chk("clr4_irq", 32'(IRQ), 32'h0);
    cyc("rd4b", 0, 1, 3'd4, 8'h00, '0);
    chk("rd4b_const", 32'(READ_DATA), 32'h00);

    // set wins over same-cycle clear
    cyc("setclr5", 1, 0, 3'd5, 8'h01, 16'h0100);
    cyc("rd5", 0, 1, 3'd5, 8'h00, '0);
    chk("rd5_const", 32'(READ_DATA), 32'h01);
    cyc("clr5", 1, 0, 3'd5, 8'h01, '0);

    // out-of-range read and write
    cyc("wr0", 1, 0, 3'd0, 8'h77, '0);
    cyc("rd7", 0, 1, 3'd7, 8'h00, '0);
    chk("rd7_rdata", 32'(READ_DATA), 32'h0);
    chk("rd7_valid", 32'(READ_VALID), 32'h1);
    chk("rd7_err", 32'(ERR), 32'h1);
    cyc("wr6", 1, 0, 3'd6, 8'hFF, '0);
    chk("wr6_err", 32'(ERR), 32'h1);
    chk("wr6_ctrl", 32'(CTRL_OUT), 32'h00A5_0077);

    // read and write the same address in one cycle
    cyc("wr1", 1, 0, 3'd1, 8'h11, '0);
    cyc("rw1", 1, 1, 3'd1, 8'h3C, '0);
    chk("rw1_old", 32'(READ_DATA), 32'h11);
    cyc("rd1", 0, 1, 3'd1, 8'h00, '0);
    chk("rd1_new", 32'(READ_DATA), 32'h3C);

    // back-to-back reads
    cyc("b2b_a", 0, 1, 3'd0, 8'h00, '0);
    cyc("b2b_b", 0, 1, 3'd2, 8'h00, '0);

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      logic [NSTAT*DW-1:0] s;
      s = ($urandom_range(0, 3) == 0) ? NSTAT*DW'($urandom) : '0;
      cyc("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          AW'($urandom_range(0, 7)), DW'($urandom), s);
    end

    // reset while a read response is pending, with nonzero contents
    cyc("pre_rst_w", 1, 0, 3'd3, 8'h5A, 16'h8101);
    cyc("pre_rst_r", 0, 1, 3'd3, 8'h00, '0);
    chk("pre_rst_valid", 32'(READ_VALID), 32'h1);
    RST = 1'b1;
    #1;
    chk("rst_pending_valid", 32'(READ_VALID), 32'h0);
    @(posedge CLK);
    #1;
    m_clear();
    check_outputs("rst_edge");
    RST = 1'b0;
    cyc("post_rst_idle", 0, 0, 3'd0, 8'h00, '0);
    cyc("post_rst_rd4", 0, 1, 3'd4, 8'h00, '0);
    chk("post_rst_rd4_const", 32'(READ_DATA), 32'h0);
    cyc("post_rst_rd5", 0, 1, 3'd5, 8'h00, '0);
    chk("post_rst_rd5_const", 32'(READ_DATA), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
